// File: rtl/data_memory_be.sv
// Byte-addressed data memory with LB/LBU/LH/LHU/LW/SB/SH/SW, alignment checks and a sequential clear engine.
// Load result registered (1 cycle, rd_valid strobe); requests are ignored while ready is low (clearing).
module data_memory_be #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              misalign_err,
  output logic              conflict_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic             legal;
  logic             accept;
  logic             do_load;
  logic             store_we;
  logic             clear_we;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [31:0]      load_val;

  assign word_idx = addr[ADDR_W-1:2];
  assign offset   = addr[1:0];

  always_comb begin
    legal = 1'b0;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~offset[0];
      2'b10:   legal = (offset == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept   = ready & (mem_read ^ mem_write);
  assign do_load  = accept & mem_read & legal;
  assign store_we = rst_n & accept & mem_write & legal;
  assign clear_we = rst_n & (state == S_CLEAR);

  always_comb begin
    state_next = state;
    if (state == S_CLEAR && clr_idx == IDX_W'(DEPTH - 1))
      state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    else        state <= state_next;
  end

  // ready tracks the state register it would be decoded from, so it rises on the edge that leaves CLEAR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
      ready <= (state_next == S_IDLE);
    end
  end

  always_comb begin
    be    = 4'b0000;
    wdata = data_in;
    case (size)
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{data_in[7:0]}};
      end
      2'b01: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array has no reset so it can map onto a byte-enabled RAM
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_idx] <= '0;
    end else if (store_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[word_idx];

  always_comb begin
    load_val = rdata;
    case (size)
      2'b00: begin
        load_val[7:0]  = rdata[{offset, 3'b000} +: 8];
        load_val[31:8] = load_unsigned ? 24'h0 : {24{load_val[7]}};
      end
      2'b01: begin
        load_val[15:0]  = offset[1] ? rdata[31:16] : rdata[15:0];
        load_val[31:16] = load_unsigned ? 16'h0 : {16{load_val[15]}};
      end
      default: load_val = rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out     <= '0;
      rd_valid     <= 1'b0;
      misalign_err <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      if (do_load) data_out <= load_val;
      rd_valid     <= do_load;
      misalign_err <= accept & ~legal;
      conflict_err <= ready & mem_read & mem_write;
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Randomized bench for data_memory_be against a byte-array reference model.
module tb_data_memory_be;

  localparam int AW = 10;
  localparam int NBYTES = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read, mem_write, load_unsigned;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          rd_valid, ready, misalign_err, conflict_err;

  data_memory_be dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .data_in(data_in),
    .data_out(data_out), .rd_valid(rd_valid), .ready(ready),
    .misalign_err(misalign_err), .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mdl [NBYTES];
  logic [31:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_read = 0; mem_write = 0; size = 2'b10; load_unsigned = 0; addr = '0; data_in = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    set_idle();
    cycle();
    cycle();
    check({tag, ".ready"}, 32'(ready), 0);
    check({tag, ".dout"}, data_out, 0);
    check({tag, ".pulses"}, {29'h0, rd_valid, misalign_err, conflict_err}, 0);
    exp_dout = '0;
    rst_n = 1;
  endtask

  // Drive junk requests while the memory is clearing; none may have any visible effect.
  task automatic wait_clear(input int n, input bit expect_rise, input string tag);
    int bad = 0;
    for (int i = 1; i <= n; i++) begin
      mem_read = 1'($urandom); mem_write = 1'($urandom); size = 2'($urandom);
      load_unsigned = 1'($urandom); addr = AW'($urandom); data_in = $urandom;
      cycle();
      if (i < n || !expect_rise)
        if (ready || rd_valid || misalign_err || conflict_err || data_out !== exp_dout) bad++;
    end
    set_idle();
    check({tag, ".quiet"}, bad, 0);
    if (expect_rise) check({tag, ".ready"}, 32'(ready), 1);
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] a, input logic [31:0] din, input string tag);
    int          ai, nb;
    bit          legal, exp_rv, exp_mis, exp_con;
    logic [31:0] v;
    mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns; addr = a; data_in = din;
    cycle();
    set_idle();
    ai = int'(a);
    nb = 1 << sz;
    legal = (sz == 0) || (sz == 1 && ai % 2 == 0) || (sz == 2 && ai % 4 == 0);
    exp_rv = 0; exp_mis = 0; exp_con = 0;
    if (rd && wr) exp_con = 1;
    else if (rd || wr) begin
      if (!legal) exp_mis = 1;
      else if (rd) begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (32'(mdl[ai + k]) << (8 * k));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
        exp_dout = v;
        exp_rv = 1;
      end else
        for (int k = 0; k < nb; k++) mdl[ai + k] = 8'(din >> (8 * k));
    end
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rv));
    check({tag, ".misalign"}, 32'(misalign_err), 32'(exp_mis));
    check({tag, ".conflict"}, 32'(conflict_err), 32'(exp_con));
    check({tag, ".dout"}, data_out, exp_dout);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int            pick;
    rst_n = 0;
    set_idle();
    exp_dout = '0;

    do_reset("t1.rst");
    model_clear();
    wait_clear(256, 1, "t1.clr");
    do_op(1, 0, 2'b10, 0, 10'h3FC, 0, "t1.lw");
    check("t1.val", data_out, 32'h0000_0000);

    do_op(0, 1, 2'b10, 0, 10'h010, 32'hDEAD_BEEF, "t2.sw");
    do_op(1, 0, 2'b10, 0, 10'h010, 0, "t2.lw");
    check("t2.val", data_out, 32'hDEAD_BEEF);
    do_op(0, 0, 2'b10, 0, 10'h010, 0, "t2.idle");

    do_op(1, 0, 2'b00, 0, 10'h011, 0, "t3.lb");
    check("t3.lb.val", data_out, 32'hFFFF_FFBE);
    do_op(1, 0, 2'b00, 1, 10'h011, 0, "t3.lbu");
    check("t3.lbu.val", data_out, 32'h0000_00BE);
    do_op(1, 0, 2'b01, 0, 10'h012, 0, "t3.lh");
    check("t3.lh.val", data_out, 32'hFFFF_DEAD);
    do_op(0, 1, 2'b00, 0, 10'h013, 32'h0000_0055, "t3.sb");
    do_op(1, 0, 2'b10, 0, 10'h010, 0, "t3.lw");
    check("t3.lw.val", data_out, 32'h55AD_BEEF);

    do_op(0, 1, 2'b10, 0, 10'h012, 32'h1111_2222, "t4.sw_mis");
    do_op(1, 0, 2'b10, 0, 10'h010, 0, "t4.lw");
    check("t4.lw.val", data_out, 32'h55AD_BEEF);
    do_op(1, 0, 2'b01, 0, 10'h011, 0, "t4.lh_mis");
    do_op(1, 0, 2'b11, 0, 10'h010, 0, "t4.size11");

    do_op(1, 1, 2'b10, 0, 10'h010, 32'h1234_5678, "t5.both");
    do_op(0, 0, 2'b10, 0, 10'h000, 0, "t5.idle");
    do_op(1, 0, 2'b10, 0, 10'h010, 0, "t5.lw");
    check("t5.lw.val", data_out, 32'h55AD_BEEF);

    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      pick = $urandom_range(0, 9);
      do_op(pick < 4 || pick == 8, (pick >= 4 && pick < 8) || pick == 8, 2'($urandom),
            1'($urandom), ra, $urandom, "rnd");
    end

    do_op(1, 0, 2'b10, 0, 10'h010, 0, "t6.pre");
    do_reset("t6.rst1");
    wait_clear(100, 0, "t6.part");
    do_reset("t6.rst2");
    model_clear();
    wait_clear(256, 1, "t6.clr");
    for (int w = 0; w < 16; w++) do_op(1, 0, 2'b10, 0, AW'(w * 4), 0, "t6.zero");
    check("t6.val", data_out, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
